// File: rtl/axis_icrc_field_masker.sv
// rtl/axis_icrc_field_masker.sv - RoCEv2 ICRC variant-field masker with skid-buffered AXI4-Stream output
//
// Purpose:
//   ORs 1s into the variant header fields of each frame so the ICRC CRC32
//   engine sees them as all-ones. The IPv4 or IPv6 mask table is chosen
//   per frame, and masking can be switched off at runtime. Each output beat
//   carries both the masked data (for the CRC engine) and the original data
//   (for the payload path) under a single handshake.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_axis_t*                 input stream (tdata/tkeep/tvalid/tready/tlast/tuser)
//   cfg_ipv6                  1 = IPv6 mask table; sampled on the first beat of a frame
//   cfg_mask_en               0 = pass data unmasked; sampled on the first beat of a frame
//   m_axis_masked_t*          output stream with masked tdata
//   m_axis_not_masked_tdata   original tdata for the same output beat
//   stat_frame_cnt            accepted-frame counter (only with AXIS_ICRC_MASK_FRAME_CNT_EN)
//
// Build option: define AXIS_ICRC_MASK_FRAME_CNT_EN to add stat_frame_cnt.

module axis_icrc_field_masker #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int MASK_BITS  = 512,
  // Eth+IPv4: DSCP/ECN (byte 15), TTL (22), IP csum (24-25), UDP csum (40-41), BTH resv8a (46)
  parameter logic [MASK_BITS-1:0] MASK_IPV4 = MASK_BITS'((512'hFF << 120) | (512'hFF << 176) |
                                                         (512'hFFFF << 192) | (512'hFFFF << 320) |
                                                         (512'hFF << 368)),
  // Eth+IPv6: TC/FlowLabel (bytes 14-17), HopLimit (21), UDP csum (60-61).
  // BTH resv8a sits at byte 66, beyond the default 512-bit span.
  parameter logic [MASK_BITS-1:0] MASK_IPV6 = MASK_BITS'((512'h0F << 112) | (512'hFF_FFFF << 120) |
                                                         (512'hFF << 168) | (512'hFFFF << 480))
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  cfg_ipv6,
  input  logic                  cfg_mask_en,
  output logic [DATA_WIDTH-1:0] m_axis_masked_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_masked_tkeep,
  output logic                  m_axis_masked_tvalid,
  input  logic                  m_axis_masked_tready,
  output logic                  m_axis_masked_tlast,
  output logic [USER_WIDTH-1:0] m_axis_masked_tuser,
`ifdef AXIS_ICRC_MASK_FRAME_CNT_EN
  output logic [31:0]           stat_frame_cnt,
`endif
  output logic [DATA_WIDTH-1:0] m_axis_not_masked_tdata
);

  localparam int MASK_BEATS = (MASK_BITS + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int CNT_W      = $clog2(MASK_BEATS + 1);
  localparam int PAD_BITS   = MASK_BEATS * DATA_WIDTH;

  // Zero-extend the tables to whole beats so bits above MASK_BITS read as 0.
  localparam logic [PAD_BITS-1:0] PAD_IPV4 = PAD_BITS'(MASK_IPV4);
  localparam logic [PAD_BITS-1:0] PAD_IPV6 = PAD_BITS'(MASK_IPV6);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] mdata;
    logic [DATA_WIDTH-1:0] ndata;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
  } beat_t;

  logic             s_tready_q, s_tready_d;
  logic             out_valid_q, out_valid_d;
  logic             tmp_valid_q, tmp_valid_d;
  beat_t            out_q, out_d, tmp_q, tmp_d, in_beat;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             frame_start_q, frame_start_d;
  logic             ipv6_q, ipv6_d;
  logic             mask_en_q, mask_en_d;

  logic                  accept;
  logic                  sel_ipv6, sel_en;
  logic [DATA_WIDTH-1:0] mask_slice, keep_expand;

  assign accept = s_axis_tvalid & s_tready_q;

  // The first beat of a frame uses the live cfg inputs; later beats use the latched copy.
  assign sel_ipv6 = frame_start_q ? cfg_ipv6    : ipv6_q;
  assign sel_en   = frame_start_q ? cfg_mask_en : mask_en_q;

  always_comb begin
    mask_slice  = '0;
    keep_expand = '0;
    // beat_cnt == MASK_BEATS matches no entry, leaving the slice at zero.
    for (int b = 0; b < MASK_BEATS; b++) begin
      if (beat_cnt_q == CNT_W'(b)) begin
        mask_slice = sel_ipv6 ? PAD_IPV6[b*DATA_WIDTH +: DATA_WIDTH]
                              : PAD_IPV4[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int k = 0; k < KEEP_WIDTH; k++) begin
      keep_expand[k*8 +: 8] = {8{s_axis_tkeep[k]}};
    end
    in_beat.mdata = sel_en ? (s_axis_tdata | (mask_slice & keep_expand)) : s_axis_tdata;
    in_beat.ndata = s_axis_tdata;
    in_beat.keep  = s_axis_tkeep;
    in_beat.last  = s_axis_tlast;
    in_beat.user  = s_axis_tuser;
  end

  // Frame tracking: only handshaked beats advance the counter or frame state.
  always_comb begin
    beat_cnt_d    = beat_cnt_q;
    frame_start_d = frame_start_q;
    ipv6_d        = ipv6_q;
    mask_en_d     = mask_en_q;
    if (accept) begin
      frame_start_d = s_axis_tlast;
      if (frame_start_q) begin
        ipv6_d    = cfg_ipv6;
        mask_en_d = cfg_mask_en;
      end
      if (s_axis_tlast) begin
        beat_cnt_d = '0;
      end else if (beat_cnt_q != CNT_W'(MASK_BEATS)) begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
    end
  end

  // Output register plus skid entry. Ready is registered, so while ready is
  // high the skid entry is always empty and can absorb one beat when the
  // downstream stalls.
  always_comb begin
    s_tready_d  = m_axis_masked_tready | (~tmp_valid_q & ~out_valid_q);
    out_valid_d = out_valid_q;
    tmp_valid_d = tmp_valid_q;
    out_d       = out_q;
    tmp_d       = tmp_q;
    if (s_tready_q) begin
      if (m_axis_masked_tready | ~out_valid_q) begin
        out_valid_d = s_axis_tvalid;
        out_d       = in_beat;
      end else begin
        tmp_valid_d = s_axis_tvalid;
        tmp_d       = in_beat;
      end
    end else if (m_axis_masked_tready) begin
      out_valid_d = tmp_valid_q;
      out_d       = tmp_q;
      tmp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_tready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      tmp_valid_q   <= 1'b0;
      out_q         <= '0;
      tmp_q         <= '0;
      beat_cnt_q    <= '0;
      frame_start_q <= 1'b1;
      ipv6_q        <= 1'b0;
      mask_en_q     <= 1'b0;
    end else begin
      s_tready_q    <= s_tready_d;
      out_valid_q   <= out_valid_d;
      tmp_valid_q   <= tmp_valid_d;
      out_q         <= out_d;
      tmp_q         <= tmp_d;
      beat_cnt_q    <= beat_cnt_d;
      frame_start_q <= frame_start_d;
      ipv6_q        <= ipv6_d;
      mask_en_q     <= mask_en_d;
    end
  end

  assign s_axis_tready           = s_tready_q;
  assign m_axis_masked_tvalid    = out_valid_q;
  assign m_axis_masked_tdata     = out_q.mdata;
  assign m_axis_not_masked_tdata = out_q.ndata;
  assign m_axis_masked_tkeep     = out_q.keep;
  assign m_axis_masked_tlast     = out_q.last;
  assign m_axis_masked_tuser     = out_q.user;

`ifdef AXIS_ICRC_MASK_FRAME_CNT_EN
  logic [31:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = (accept & s_axis_tlast) ? frame_cnt_q + 32'd1 : frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign stat_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_axis_icrc_field_masker.sv
// tb/tb_axis_icrc_field_masker.sv - scoreboard bench for axis_icrc_field_masker
module tb_axis_icrc_field_masker;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int UW = 1;
  localparam int MB = 128;
  localparam logic [127:0] M4 = 128'h00ff_0000_0000_0000_0000_0000_0000_ff00;
  localparam logic [127:0] M6 = 128'h0000_0000_ffff_0000_0000_0000_00ff_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [UW-1:0] s_tuser;
  logic          cfg_ipv6;
  logic          cfg_mask_en;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [UW-1:0] m_tuser;
  logic [DW-1:0] m_ndata;
`ifdef AXIS_ICRC_MASK_FRAME_CNT_EN
  logic [31:0]   stat_frame_cnt;
`endif

  axis_icrc_field_masker #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .MASK_BITS(MB),
    .MASK_IPV4(M4), .MASK_IPV6(M6)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .cfg_ipv6(cfg_ipv6), .cfg_mask_en(cfg_mask_en),
    .m_axis_masked_tdata(m_tdata), .m_axis_masked_tkeep(m_tkeep),
    .m_axis_masked_tvalid(m_tvalid), .m_axis_masked_tready(m_tready),
    .m_axis_masked_tlast(m_tlast), .m_axis_masked_tuser(m_tuser),
`ifdef AXIS_ICRC_MASK_FRAME_CNT_EN
    .stat_frame_cnt(stat_frame_cnt),
`endif
    .m_axis_not_masked_tdata(m_ndata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] m;
    logic [DW-1:0] n;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   m_idx = 0;
  int   exp_frames = 0;
  bit   f_v6, f_en;
  int   mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: byte-wise mask lookup by absolute byte offset within the frame.
  function automatic logic [DW-1:0] model_mask(input logic [DW-1:0] d, input logic [KW-1:0] k,
                                               input int idx, input bit v6, input bit en);
    logic [127:0]  m;
    logic [DW-1:0] r;
    m = v6 ? M6 : M4;
    r = d;
    if (en) begin
      for (int j = 0; j < KW; j++) begin
        int g;
        g = idx * KW + j;
        if (k[j] && g < MB / 8) r[j*8 +: 8] = r[j*8 +: 8] | m[g*8 +: 8];
      end
    end
    return r;
  endfunction

  // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ($urandom_range(0, 3) != 0);
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Monitor: a handshake visible at the negedge completes on the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && m_tvalid && m_tready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat actual=%h required=none", m_tdata);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("masked_tdata", m_tdata, e.m);
          chk("not_masked_tdata", m_ndata, e.n);
          chk("tkeep", 64'(m_tkeep), 64'(e.k));
          chk("tlast", 64'(m_tlast), 64'(e.l));
          chk("tuser", 64'(m_tuser), 64'(e.u));
        end
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                           input logic [UW-1:0] u, input bit v6, input bit en);
    int n;
    n = 0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u;
    cfg_ipv6 = v6; cfg_mask_en = en; s_tvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      n++;
      if (n > 500) break;
    end
    if (n > 500) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=stalled required=accepted");
    end else begin
      exp_t e;
      if (m_idx == 0) begin
        f_v6 = v6;
        f_en = en;
      end
      e.m = model_mask(d, k, m_idx, f_v6, f_en);
      e.n = d; e.k = k; e.l = l; e.u = u;
      q.push_back(e);
      if (l) begin
        m_idx = 0;
        exp_frames++;
      end else begin
        m_idx++;
      end
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    s_tuser = '0; cfg_ipv6 = 1'b0; cfg_mask_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd0);
    chk("rst_mdata", m_tdata, 64'd0);
    chk("rst_ndata", m_ndata, 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
`ifdef AXIS_ICRC_MASK_FRAME_CNT_EN
    chk("rst_stat", 64'(stat_frame_cnt), 64'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("tready_after_rst", 64'(s_tready), 64'd1);

    // IPv4 4-beat frame of zeros; output valid one clock after acceptance.
    for (int b = 0; b < 4; b++) begin
      send_beat(64'd0, 8'hFF, b == 3, 1'b0, 1'b0, 1'b1);
      if (b == 0) chk("latency_tvalid", 64'(m_tvalid), 64'd1);
    end
    // IPv6 on beat 0, cfg toggled to IPv4 mid-frame: latched IPv6 must persist.
    send_beat(64'd0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
    send_beat(64'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    send_beat(64'd0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
    // Masking disabled.
    for (int b = 0; b < 3; b++) send_beat(64'h1234_5678_9abc_def0, 8'hFF, b == 2, 1'b1, 1'b0, 1'b0);
    // Single-beat frame, only lane 0 enabled: byte 1 mask suppressed.
    send_beat(64'd0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    // Frame longer than the mask span, then a short frame restarting at beat 0.
    for (int b = 0; b < 5; b++) send_beat({$urandom, $urandom}, 8'hFF, b == 4, 1'b0, 1'b1, 1'b1);
    send_beat(64'd0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);

    // Back-to-back 2-beat frames with a 3-clock downstream stall.
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    mode = 2;
    send_beat({$urandom, $urandom}, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("stall_tready_drop", 64'(s_tready), 64'd0);
    repeat (2) @(posedge clk);
    #1 mode = 0;
    send_beat(64'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    send_beat(64'd0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset after beat 1 of a 4-beat frame.
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    q.delete();
    m_idx = 0;
    exp_frames = 0;
    chk("rst_midframe_tvalid", 64'(m_tvalid), 64'd0);
`ifdef AXIS_ICRC_MASK_FRAME_CNT_EN
    chk("rst_midframe_stat", 64'(stat_frame_cnt), 64'd0);
`endif
    rst = 1'b0;
    send_beat(64'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    send_beat(64'd0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef AXIS_ICRC_MASK_FRAME_CNT_EN
    chk("stat_after_frame", 64'(stat_frame_cnt), 64'd1);
`endif

    // Randomized frames, per-beat random cfg, random backpressure and gaps.
    mode = 1;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        logic [KW-1:0] k;
        k = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
        send_beat({$urandom, $urandom}, k, b == len - 1, 1'($urandom),
                  1'($urandom), ($urandom_range(0, 4) != 0));
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk); #1;
        end
      end
    end

    mode = 0;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
`ifdef AXIS_ICRC_MASK_FRAME_CNT_EN
    chk("stat_final", 64'(stat_frame_cnt), 64'(exp_frames));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
